// File: rtl/gsquare_if.sv
// -----------------------------------------------------------------------------
// gsquare_if -- stream/bus bundle for the gsquare stochastic squaring unit.
//
// Signals:
//   en       advance enable; low freezes the counter and zeroes out
//   randNum  WIDTH-bit uniform random number, independent of the in source
//   in       unipolar input bitstream
//   out      registered squared bitstream
//   cnt_o    current counter value (binary estimate of P(in) * 2^WIDTH)
//
// Modports:
//   master   stream source / observer (drives en, randNum, in)
//   slave    the gsquare unit (drives out, cnt_o)
// -----------------------------------------------------------------------------
interface gsquare_if #(
    parameter int unsigned WIDTH = 5
);
    logic             en;
    logic [WIDTH-1:0] randNum;
    logic             in;
    logic             out;
    logic [WIDTH-1:0] cnt_o;

    modport master (
        output en,
        output randNum,
        output in,
        input  out,
        input  cnt_o
    );

    modport slave (
        input  en,
        input  randNum,
        input  in,
        output out,
        output cnt_o
    );
endinterface : gsquare_if

// File: rtl/gsquare.sv
// -----------------------------------------------------------------------------
// gsquare -- stochastic squaring unit for unipolar bitstreams.
//
// out carries P(in)^2 with one cycle of latency. A saturating up/down counter
// tracks the running probability of in; comparing it against an independent
// random number regenerates a copy of the stream that is decorrelated from the
// current input bit. The live input ANDed with that copy is registered as out.
// Inverse of the stochastic square-root unit in the same library.
//
// Parameters:
//   WIDTH  counter and random-number width; stream resolution is 2^WIDTH
//   INIT   counter value loaded at reset (must be <= 2^WIDTH-1)
//
// Ports:
//   clk    single clock, rising edge
//   rst    synchronous, active-high reset (priority over everything)
//   bus    gsquare_if slave modport: en, randNum, in -> out, cnt_o
// -----------------------------------------------------------------------------
module gsquare #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned INIT  = 2 ** (WIDTH - 1)
) (
    input  logic      clk,
    input  logic      rst,
    gsquare_if.slave  bus
);

    localparam logic [WIDTH-1:0] CNT_INIT = INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_MIN  = '0;

    // Counter action chosen each cycle.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             regen;
    cnt_op_e          cnt_op;

    // Regenerated stream: P(regen) = cnt / 2^WIDTH. It is 0 whenever cnt is 0,
    // and with cnt at maximum it is 0 only for the all-ones random number.
    assign regen = (cnt_q > bus.randNum);

    // Next-state logic.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_op = CNT_HOLD;
        cnt_d  = cnt_q;
        out_d  = 1'b0;

        if (bus.en) begin
            // regen comes from the pre-update counter, so the current input
            // bit never influences its own partner bit.
            out_d = bus.in & regen;

            // The counter moves only when in and regen disagree; the bound
            // checks keep it from wrapping in either direction.
            if (bus.in && !regen && (cnt_q != CNT_MAX)) begin
                cnt_op = CNT_INC;
            end else if (!bus.in && regen && (cnt_q != CNT_MIN)) begin
                cnt_op = CNT_DEC;
            end
        end

        unique case (cnt_op)
            CNT_INC:  cnt_d = cnt_q + 1'b1;
            CNT_DEC:  cnt_d = cnt_q - 1'b1;
            default:  cnt_d = cnt_q;
        endcase
    end

    // State registers. Reset discards the accumulated estimate entirely.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_INIT;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    // Outputs come straight from flops: no combinational input-to-output path.
    assign bus.out   = out_q;
    assign bus.cnt_o = cnt_q;

endmodule : gsquare

// File: tb/tb_gsquare.sv
// -----------------------------------------------------------------------------
// tb_gsquare -- self-checking bench for gsquare (WIDTH=5, INIT=16).
// Directed vectors with hand-computed expectations, plus LFSR-driven
// statistical runs checked against tolerance bands.
// -----------------------------------------------------------------------------
module tb_gsquare;

    localparam int unsigned WIDTH = 5;

    logic clk = 1'b0;
    logic rst;

    gsquare_if #(.WIDTH(WIDTH)) bus ();

    gsquare #(.WIDTH(WIDTH), .INIT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] lfsr16;
    logic [4:0]  lfsr5;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Galois LFSRs: x^16+x^14+x^13+x^11+1 and x^5+x^3+1.
    task automatic step_lfsrs();
        lfsr16 = {1'b0, lfsr16[15:1]} ^ (lfsr16[0] ? 16'hB400 : 16'h0000);
        lfsr5  = {1'b0, lfsr5[4:1]}   ^ (lfsr5[0]  ? 5'h14    : 5'h00);
    endtask

    // Drive LFSR stimulus; p75=0 gives P(in)=0.5, p75=1 gives P(in)=0.75.
    task automatic run_stat(input bit p75, input int n_discard, input int n_count,
                            output int ones);
        ones = 0;
        for (int i = 0; i < n_discard + n_count; i++) begin
            bus.in      = p75 ? (lfsr16[0] | lfsr16[1]) : lfsr16[0];
            bus.randNum = lfsr5;
            step_lfsrs();
            tick();
            if (i >= n_discard) ones += int'(bus.out);
        end
    endtask

    initial begin
        int ones;

        rst         = 1'b1;
        bus.en      = 1'b1;
        bus.in      = 1'b1;
        bus.randNum = 5'd31;
        lfsr16      = 16'hACE1;
        lfsr5       = 5'h13;

        // Reset held two cycles with in=1, en=1.
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("reset_cnt_%0d", i), int'(bus.cnt_o), 16);
            check($sformatf("reset_out_%0d", i), int'(bus.out), 0);
        end

        // Upward saturation: in=1, randNum=31 -> regen=0, count up to 31.
        rst = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check($sformatf("up_cnt_%0d", k), int'(bus.cnt_o), 16 + k);
            check($sformatf("up_out_%0d", k), int'(bus.out), 0);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("up_sat_cnt_%0d", k), int'(bus.cnt_o), 31);
            check($sformatf("up_sat_out_%0d", k), int'(bus.out), 0);
        end
        bus.randNum = 5'd0;
        tick();
        check("up_rand0_out", int'(bus.out), 1);
        check("up_rand0_cnt", int'(bus.cnt_o), 31);

        // Downward saturation: in=0, randNum=0 -> 15..0 then hold, no wrap.
        bus.in = 1'b0;
        do_reset();
        check("down_reset_cnt", int'(bus.cnt_o), 16);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("down_cnt_%0d", k), int'(bus.cnt_o), 16 - k);
            check($sformatf("down_out_%0d", k), int'(bus.out), 0);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("down_sat_cnt_%0d", k), int'(bus.cnt_o), 0);
        end

        // Enable freeze: bring cnt to 20, make out=1, then hold with en=0.
        bus.in      = 1'b1;
        bus.randNum = 5'd31;
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        check("frz_pre_cnt", int'(bus.cnt_o), 20);
        bus.randNum = 5'd0;
        tick();
        check("frz_pre_out", int'(bus.out), 1);
        check("frz_pre_hold", int'(bus.cnt_o), 20);
        bus.en      = 1'b0;
        bus.randNum = 5'd31;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("frz_cnt_%0d", k), int'(bus.cnt_o), 20);
            check($sformatf("frz_out_%0d", k), int'(bus.out), 0);
        end
        bus.en = 1'b1;
        tick();
        check("frz_resume_cnt", int'(bus.cnt_o), 21);

        // Statistical: p=0.5 -> 256 +/- 40 ones in 1024 cycles.
        do_reset();
        run_stat(1'b0, 64, 1024, ones);
        $display("stat p=0.50: %0d ones in 1024", ones);
        check("stat_p50_band", int'(ones >= 216 && ones <= 296), 1);

        // Statistical: p=0.75 -> 576 +/- 50.
        do_reset();
        run_stat(1'b1, 64, 1024, ones);
        $display("stat p=0.75: %0d ones in 1024", ones);
        check("stat_p75_band", int'(ones >= 526 && ones <= 626), 1);

        // Reset mid-run, then reconverge.
        do_reset();
        run_stat(1'b0, 300, 0, ones);
        bus.in = 1'b1;
        rst    = 1'b1;
        tick();
        check("midrst_cnt", int'(bus.cnt_o), 16);
        check("midrst_out", int'(bus.out), 0);
        rst = 1'b0;
        run_stat(1'b0, 64, 1024, ones);
        $display("stat after reset p=0.50: %0d ones in 1024", ones);
        check("midrst_p50_band", int'(ones >= 216 && ones <= 296), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_gsquare
